// File: rtl/pgm_prot_mailbox_pkg.sv
// Shared definitions for the PGM protection mailbox: register map, opcodes,
// STATUS bit positions and the bus/engine state encodings.
package pgm_prot_pkg;

  localparam logic [3:0] REG_CMD    = 4'd0;
  localparam logic [3:0] REG_ARG0   = 4'd1;
  localparam logic [3:0] REG_ARG1   = 4'd2;
  localparam logic [3:0] REG_STATUS = 4'd3;
  localparam logic [3:0] REG_RES_LO = 4'd4;
  localparam logic [3:0] REG_RES_HI = 4'd5;
  localparam logic [3:0] REG_KEY    = 4'd6;
  localparam logic [3:0] REG_ID     = 4'd7;

  localparam logic [7:0] OP_ADD = 8'h01;
  localparam logic [7:0] OP_MUL = 8'h02;
  localparam logic [7:0] OP_XOR = 8'h03;

  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  localparam int ST_ERR  = 2;
  localparam int ST_OVR  = 3;

  typedef enum logic [1:0] {B_IDLE, B_WAIT, B_ACK} bus_state_e;
  typedef enum logic [1:0] {E_IDLE, E_RUN, E_DONE} eng_state_e;

  // 68000 byte lanes: uds_n owns [15:8], lds_n owns [7:0].
  function automatic logic [15:0] merge_bytes(input logic [15:0] cur,
                                              input logic [15:0] wdata,
                                              input logic        uds_n,
                                              input logic        lds_n);
    logic [15:0] r;
    r = cur;
    if (!uds_n) r[15:8] = wdata[15:8];
    if (!lds_n) r[7:0]  = wdata[7:0];
    return r;
  endfunction

  function automatic logic op_valid(input logic [7:0] op, input logic mul_en);
    return (op == OP_ADD) || (op == OP_XOR) || (mul_en && (op == OP_MUL));
  endfunction

endpackage

// File: rtl/pgm_prot_mailbox_if.sv
// 68000-side word-register bus seen by the PGM protection mailbox.
interface pgm_prot_mailbox_if;
  logic        sel;
  logic        rw_n;
  logic        uds_n;
  logic        lds_n;
  logic [3:0]  addr;
  logic [15:0] din;
  logic [15:0] dout;
  logic        dtack_n;

  modport master (output sel, rw_n, uds_n, lds_n, addr, din,
                  input  dout, dtack_n);
  modport slave  (input  sel, rw_n, uds_n, lds_n, addr, din,
                  output dout, dtack_n);
endinterface

// File: rtl/pgm_prot_mul16.sv
// 16x16 unsigned shift-add multiplier, one partial product per clock.
// done_o marks the final step; product_o carries the full product that cycle.
module pgm_prot_mul16 (
  input  logic        fixed_20m_clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic        done_o,
  output logic [31:0] product_o
);

  logic [31:0] acc_q, acc_d;
  logic [31:0] mcand_q, mcand_d;
  logic [15:0] mplier_q, mplier_d;
  logic [4:0]  cnt_q, cnt_d;

  always_comb begin
    // NOTE: every _d starts as its _q so no path leaves it unassigned,
    // which would otherwise infer a latch.
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (start_i) begin
      acc_d    = '0;
      mcand_d  = {16'd0, a_i};
      mplier_d = b_i;
      cnt_d    = 5'd16;
    end else if (cnt_q != 5'd0) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - 5'd1;
    end
  end

  assign done_o    = (cnt_q == 5'd1);
  assign product_o = acc_d;

  always_ff @(posedge fixed_20m_clk) begin
    // NOTE: non-blocking so every flop samples pre-edge values no matter
    // the statement order.
    if (reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/pgm_prot_mailbox.sv
// PGM protection window responder: DTACK after a fixed wait plus a small
// ADD/MUL/XOR command engine. Define PGM_PROT_MUL_EN to build the multiplier.
module pgm_prot_mailbox
  import pgm_prot_pkg::*;
#(
  parameter int          WAIT_CYCLES = 2,
  parameter logic [15:0] ID_VALUE    = 16'h0027
) (
  input  logic               fixed_20m_clk,
  input  logic               reset,
  pgm_prot_mailbox_if.slave  bus
);

  bus_state_e  bus_q, bus_d;
  logic [2:0]  wait_cnt_q, wait_cnt_d;
  logic        sel_prev_q, sel_prev_d;
  logic        dtack_n_q, dtack_n_d;
  logic [15:0] dout_q, dout_d;
  logic        access_start, commit;

  eng_state_e  eng_q, eng_d;
  logic [7:0]  op_q, op_d;
  logic [15:0] opa_q, opa_d, opb_q, opb_d, opk_q, opk_d;
  logic [15:0] arg0_q, arg0_d, arg1_q, arg1_d, key_q, key_d;
  logic [15:0] res_lo_q, res_lo_d, res_hi_q, res_hi_d;
  logic        done_q, done_d, err_q, err_d, ovr_q, ovr_d;
  logic        busy;
  logic [15:0] status;
  logic        mul_done;
  logic [31:0] mul_product;

`ifdef PGM_PROT_MUL_EN
  localparam logic MUL_EN = 1'b1;
  logic mul_start;

  assign mul_start = (eng_q == E_IDLE) && (eng_d == E_RUN) && (op_d == OP_MUL);

  pgm_prot_mul16 u_mul (
    .fixed_20m_clk (fixed_20m_clk),
    .reset         (reset),
    .start_i       (mul_start),
    .a_i           (opa_d),
    .b_i           (opb_d),
    .done_o        (mul_done),
    .product_o     (mul_product)
  );
`else
  localparam logic MUL_EN = 1'b0;
  assign mul_done    = 1'b0;
  assign mul_product = '0;
`endif

  // An access only starts on a fresh rising edge of sel.
  assign access_start = bus.sel && !sel_prev_q;
  assign sel_prev_d   = bus.sel;

  always_comb begin
    bus_d      = bus_q;
    wait_cnt_d = wait_cnt_q;
    commit     = 1'b0;
    unique case (bus_q)
      B_IDLE: if (access_start) begin
        if (WAIT_CYCLES <= 1) begin
          bus_d  = B_ACK;
          commit = 1'b1;
        end else begin
          bus_d      = B_WAIT;
          wait_cnt_d = 3'(WAIT_CYCLES - 1);
        end
      end
      B_WAIT: if (wait_cnt_q <= 3'd1) begin
        bus_d  = B_ACK;
        commit = 1'b1;
      end else begin
        wait_cnt_d = wait_cnt_q - 3'd1;
      end
      B_ACK:  if (!bus.sel) bus_d = B_IDLE;
      default: bus_d = B_IDLE;
    endcase
    dtack_n_d = (bus_d != B_ACK);
  end

  assign busy = (eng_q != E_IDLE);

  always_comb begin
    status          = '0;
    status[ST_BUSY] = busy;
    status[ST_DONE] = done_q;
    status[ST_ERR]  = err_q;
    status[ST_OVR]  = ovr_q;
  end

  always_comb begin
    dout_d   = dout_q;
    eng_d    = eng_q;
    op_d     = op_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    opk_d    = opk_q;
    arg0_d   = arg0_q;
    arg1_d   = arg1_q;
    key_d    = key_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    done_d   = done_q;
    err_d    = err_q;
    ovr_d    = ovr_q;

    if (commit && bus.rw_n) begin
      case (bus.addr)
        REG_CMD:    dout_d = 16'h0000;
        REG_ARG0:   dout_d = arg0_q;
        REG_ARG1:   dout_d = arg1_q;
        REG_STATUS: begin
          dout_d = status;
          done_d = 1'b0;
          err_d  = 1'b0;
          ovr_d  = 1'b0;
        end
        REG_RES_LO: dout_d = res_lo_q;
        REG_RES_HI: dout_d = res_hi_q;
        REG_KEY:    dout_d = key_q;
        REG_ID:     dout_d = ID_VALUE;
        default:    dout_d = 16'hFFFF;
      endcase
    end

    if (commit && !bus.rw_n) begin
      case (bus.addr)
        REG_ARG0: arg0_d = merge_bytes(arg0_q, bus.din, bus.uds_n, bus.lds_n);
        REG_ARG1: arg1_d = merge_bytes(arg1_q, bus.din, bus.uds_n, bus.lds_n);
        REG_KEY:  key_d  = merge_bytes(key_q,  bus.din, bus.uds_n, bus.lds_n);
        REG_CMD: if (!bus.lds_n) begin
          if (busy) begin
            ovr_d = 1'b1;
          end else if (op_valid(bus.din[7:0], MUL_EN)) begin
            eng_d = E_RUN;
            op_d  = bus.din[7:0];
            opa_d = arg0_q;
            opb_d = arg1_q;
            opk_d = key_q;
          end else begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end

    // Completion sets done after any STATUS-read clear in the same cycle.
    unique case (eng_q)
      E_RUN: begin
        case (op_q)
          OP_ADD: begin
            {res_hi_d, res_lo_d} = {15'd0, ({1'b0, opa_q} + {1'b0, opb_q})};
            eng_d = E_DONE;
          end
          OP_XOR: begin
            res_lo_d = opa_q ^ opk_q;
            res_hi_d = opb_q ^ opk_q;
            eng_d    = E_DONE;
          end
          OP_MUL: if (mul_done) begin
            {res_hi_d, res_lo_d} = mul_product;
            eng_d = E_DONE;
          end
          default: eng_d = E_DONE;
        endcase
      end
      E_DONE: begin
        eng_d  = E_IDLE;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge fixed_20m_clk) begin
    if (reset) begin
      bus_q      <= B_IDLE;
      wait_cnt_q <= '0;
      sel_prev_q <= 1'b1;
      dtack_n_q  <= 1'b1;
      dout_q     <= 16'hFFFF;
      eng_q      <= E_IDLE;
      op_q       <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      opk_q      <= '0;
      arg0_q     <= '0;
      arg1_q     <= '0;
      key_q      <= '0;
      res_lo_q   <= '0;
      res_hi_q   <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      bus_q      <= bus_d;
      wait_cnt_q <= wait_cnt_d;
      sel_prev_q <= sel_prev_d;
      dtack_n_q  <= dtack_n_d;
      dout_q     <= dout_d;
      eng_q      <= eng_d;
      op_q       <= op_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      opk_q      <= opk_d;
      arg0_q     <= arg0_d;
      arg1_q     <= arg1_d;
      key_q      <= key_d;
      res_lo_q   <= res_lo_d;
      res_hi_q   <= res_hi_d;
      done_q     <= done_d;
      err_q      <= err_d;
      ovr_q      <= ovr_d;
    end
  end

  assign bus.dout    = dout_q;
  assign bus.dtack_n = dtack_n_q;

endmodule

// File: tb/tb_pgm_prot_mailbox.sv
// Directed and randomized bench for pgm_prot_mailbox against an edge-indexed
// behavioural model; honours PGM_PROT_MUL_EN when defined.
module tb_pgm_prot_mailbox;
  import pgm_prot_pkg::*;

  localparam int WAIT_CYCLES = 2;
`ifdef PGM_PROT_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic fixed_20m_clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  pgm_prot_mailbox_if bus_if ();

  pgm_prot_mailbox #(.WAIT_CYCLES(WAIT_CYCLES), .ID_VALUE(16'h0027)) dut (
    .fixed_20m_clk (fixed_20m_clk),
    .reset         (reset),
    .bus           (bus_if)
  );

  always #25 fixed_20m_clk = ~fixed_20m_clk;
  always @(posedge fixed_20m_clk) cyc <= cyc + 1;

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  // Reference model: a command committed at edge s with latency L is busy for
  // edges s..s+L-1 and shows done (with its result) from edge s+L onward.
  logic [15:0] m_arg0, m_arg1, m_key, m_res_lo, m_res_hi;
  logic [31:0] m_result;
  bit          m_done, m_err, m_ovr, m_pend;
  int          m_start, m_lat;

  function automatic void m_reset();
    m_arg0 = 0; m_arg1 = 0; m_key = 0; m_res_lo = 0; m_res_hi = 0;
    m_result = 0; m_done = 0; m_err = 0; m_ovr = 0; m_pend = 0;
    m_start = 0; m_lat = 0;
  endfunction

  function automatic void m_advance(input int e);
    if (m_pend && (m_start + m_lat <= e)) begin
      m_pend = 0;
      m_done = 1;
      {m_res_hi, m_res_lo} = m_result;
    end
  endfunction

  function automatic logic [15:0] m_lanes(input logic [15:0] old, input logic [15:0] d,
                                          input logic uds, input logic lds);
    return {uds ? old[15:8] : d[15:8], lds ? old[7:0] : d[7:0]};
  endfunction

  function automatic void m_launch(input logic [31:0] result, input int lat, input int r);
    m_result = result;
    m_lat    = lat;
    m_start  = r;
    m_pend   = 1;
  endfunction

  function automatic void m_write(input logic [3:0] a, input logic uds, input logic lds,
                                  input logic [15:0] d, input int r);
    m_advance(r - 1);
    case (a)
      REG_ARG0: m_arg0 = m_lanes(m_arg0, d, uds, lds);
      REG_ARG1: m_arg1 = m_lanes(m_arg1, d, uds, lds);
      REG_KEY:  m_key  = m_lanes(m_key, d, uds, lds);
      REG_CMD: if (!lds) begin
        if (m_pend) m_ovr = 1;
        else if (d[7:0] == 8'h01) m_launch(32'(m_arg0) + 32'(m_arg1), 2, r);
        else if (d[7:0] == 8'h03) m_launch({m_arg1 ^ m_key, m_arg0 ^ m_key}, 2, r);
        else if (d[7:0] == 8'h02 && MUL_EN) m_launch(32'(m_arg0) * 32'(m_arg1), 17, r);
        else begin
          m_done = 1;
          m_err  = 1;
        end
      end
      default: ;
    endcase
    m_advance(r);
  endfunction

  function automatic bit m_read(input logic [3:0] a, input int r, output logic [15:0] exp);
    bit ok = 1;
    m_advance(r - 1);
    case (a)
      REG_CMD:    begin exp = 16'h0000; ok = 0; end
      REG_ARG0:   exp = m_arg0;
      REG_ARG1:   exp = m_arg1;
      REG_STATUS: begin
        exp = {12'd0, m_ovr, m_err, m_done, m_pend};
        m_ovr = 0; m_err = 0; m_done = 0;
      end
      REG_RES_LO: begin exp = m_res_lo; ok = !m_pend; end
      REG_RES_HI: begin exp = m_res_hi; ok = !m_pend; end
      REG_KEY:    exp = m_key;
      REG_ID:     exp = 16'h0027;
      default:    exp = 16'hFFFF;
    endcase
    m_advance(r);
    return ok;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One complete bus cycle; returns the edge index at which the DUT committed.
  task automatic access(input bit rd, input logic [3:0] a, input logic uds, input logic lds,
                        input logic [15:0] d, output logic [15:0] rdata, output int edge_idx);
    int lat;
    @(negedge fixed_20m_clk);
    bus_if.sel = 1'b1; bus_if.rw_n = rd; bus_if.addr = a;
    bus_if.uds_n = uds; bus_if.lds_n = lds; bus_if.din = d;
    lat = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge fixed_20m_clk); #1;
      lat++;
      if (bus_if.dtack_n === 1'b0) break;
    end
    check("ack_latency", 32'(lat), 32'(WAIT_CYCLES));
    edge_idx = cyc;
    rdata    = bus_if.dout;
    @(negedge fixed_20m_clk);
    bus_if.sel = 1'b0; bus_if.rw_n = 1'b1; bus_if.uds_n = 1'b1; bus_if.lds_n = 1'b1;
    @(posedge fixed_20m_clk); #1;
    check("ack_release", 32'(bus_if.dtack_n), 32'd1);
  endtask

  task automatic mb_write(input logic [3:0] a, input logic [15:0] d,
                          input logic uds, input logic lds);
    logic [15:0] rd;
    int e;
    access(1'b0, a, uds, lds, d, rd, e);
    m_write(a, uds, lds, d, e);
  endtask

  task automatic mb_read(input logic [3:0] a, output logic [15:0] obs);
    logic [15:0] exp;
    int e;
    access(1'b1, a, 1'b0, 1'b0, 16'h0000, obs, e);
    if (m_read(a, e, exp)) check($sformatf("rd_reg%0d", a), 32'(obs), 32'(exp));
  endtask

  task automatic poll_done();
    logic [15:0] s;
    for (int i = 0; i < 12; i++) begin
      mb_read(REG_STATUS, s);
      if (s[1]) break;
    end
  endtask

  initial begin
    logic [15:0] v;
    int          gap;
    logic [7:0]  op;
    logic [3:0]  a;

    bus_if.sel = 1'b0; bus_if.rw_n = 1'b1; bus_if.uds_n = 1'b1; bus_if.lds_n = 1'b1;
    bus_if.addr = 4'd0; bus_if.din = 16'h0000;
    reset = 1'b1;
    m_reset();
    repeat (3) @(posedge fixed_20m_clk);
    #1;
    check("reset_dout", 32'(bus_if.dout), 32'h0000_FFFF);
    check("reset_dtack_n", 32'(bus_if.dtack_n), 32'd1);
    @(negedge fixed_20m_clk);
    reset = 1'b0;

    mb_read(REG_ID, v);
    check("id_value", 32'(v), 32'h0000_0027);
    mb_read(REG_STATUS, v);
    check("status_after_reset", 32'(v), 32'h0);

    mb_write(REG_ARG0, 16'hFFFF, 1'b0, 1'b0);
    mb_write(REG_ARG1, 16'h0001, 1'b0, 1'b0);
    mb_write(REG_CMD, 16'h0001, 1'b0, 1'b0);
    poll_done();
    mb_read(REG_RES_HI, v);
    check("add_res_hi", 32'(v), 32'h0000_0001);
    mb_read(REG_RES_LO, v);
    check("add_res_lo", 32'(v), 32'h0000_0000);
    mb_read(REG_STATUS, v);
    check("status_cleared", 32'(v), 32'h0);

    mb_write(REG_ARG0, 16'h1234, 1'b0, 1'b0);
    mb_write(REG_ARG1, 16'h5678, 1'b0, 1'b0);
    mb_write(REG_CMD, 16'h0002, 1'b0, 1'b0);
    poll_done();
    mb_read(REG_RES_HI, v);
`ifdef PGM_PROT_MUL_EN
    check("mul_res_hi", 32'(v), 32'h0000_0626);
    mb_read(REG_RES_LO, v);
    check("mul_res_lo", 32'(v), 32'h0000_0060);
`else
    check("nomul_res_hi_kept", 32'(v), 32'h0000_0001);
    mb_write(REG_CMD, 16'h0002, 1'b0, 1'b0);
    mb_read(REG_STATUS, v);
    check("nomul_status_err_done", 32'(v), 32'h0000_0006);
`endif

    mb_write(REG_CMD, 16'h0002, 1'b0, 1'b0);
    mb_write(REG_CMD, 16'h0003, 1'b0, 1'b0);
    repeat (20) @(posedge fixed_20m_clk);
    mb_read(REG_STATUS, v);
    mb_read(REG_STATUS, v);

    mb_write(REG_KEY, 16'hAB00, 1'b0, 1'b1);
    mb_read(REG_KEY, v);
    check("key_upper_byte", 32'(v), 32'h0000_AB00);
    mb_write(REG_ARG0, 16'h00FF, 1'b0, 1'b0);
    mb_write(REG_ARG1, 16'h0000, 1'b0, 1'b0);
    mb_write(REG_CMD, 16'h0003, 1'b0, 1'b0);
    poll_done();
    mb_read(REG_RES_LO, v);
    check("xor_res_lo", 32'(v), 32'h0000_ABFF);
    mb_read(REG_RES_HI, v);
    check("xor_res_hi", 32'(v), 32'h0000_AB00);

    for (int n = 0; n < 250; n++) begin
      gap = $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) gap = $urandom_range(4, 20);
      repeat (gap) @(posedge fixed_20m_clk);
      case ($urandom_range(0, 9))
        0, 1, 2: begin
          a = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15))
              : (($urandom_range(0, 2) == 0) ? REG_KEY
              : (($urandom_range(0, 1) == 0) ? REG_ARG0 : REG_ARG1));
          mb_write(a, 16'($urandom), 1'($urandom), 1'($urandom));
        end
        3, 4: begin
          case ($urandom_range(0, 4))
            0:       op = 8'h01;
            1:       op = 8'h02;
            2:       op = 8'h03;
            default: op = 8'($urandom);
          endcase
          mb_write(REG_CMD, {8'($urandom), op}, 1'($urandom), 1'b0);
        end
        default: mb_read(4'($urandom_range(1, 15)), v);
      endcase
    end

    @(negedge fixed_20m_clk);
    bus_if.sel = 1'b1; bus_if.rw_n = 1'b1; bus_if.addr = REG_ID;
    for (int i = 0; i < 16; i++) begin
      @(posedge fixed_20m_clk); #1;
      if (bus_if.dtack_n === 1'b0) break;
    end
    check("pre_reset_ack", 32'(bus_if.dtack_n), 32'd0);
    @(negedge fixed_20m_clk);
    reset = 1'b1;
    @(posedge fixed_20m_clk); #1;
    check("midack_reset_dtack_n", 32'(bus_if.dtack_n), 32'd1);
    check("midack_reset_dout", 32'(bus_if.dout), 32'h0000_FFFF);
    @(negedge fixed_20m_clk);
    reset = 1'b0;
    m_reset();
    for (int i = 0; i < 6; i++) begin
      @(posedge fixed_20m_clk); #1;
      check("no_ack_sel_held", 32'(bus_if.dtack_n), 32'd1);
    end
    @(negedge fixed_20m_clk);
    bus_if.sel = 1'b0;
    mb_read(4'd9, v);
    check("unmapped_read", 32'(v), 32'h0000_FFFF);
    mb_read(REG_STATUS, v);
    check("status_after_midack_reset", 32'(v), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
